// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch/next-PC stage: FSM encodings, PC source selects
// and a word-alignment helper.
package fetch_unit_pkg;

  localparam logic [1:0] FS_FETCH = 2'b00;
  localparam logic [1:0] FS_EXEC  = 2'b01;
  localparam logic [1:0] FS_HALT  = 2'b10;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_J26 = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;
  localparam logic [1:0] PCSEL_MEM = 2'b11;

  // Register and memory jump targets may carry stray low bits; fetches are word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC resolution: taken condition plus target selection.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_index_i,
  input  logic        status_z_i,
  input  logic        is_jump_i,
  input  logic        zero_branch_i,
  input  logic        need_zero_i,
  input  logic        status_branch_i,
  input  logic        need_st_z_i,
  input  logic [1:0]  pc_select_i,
  input  logic        alu_zero_i,
  input  logic [31:0] reg_target_i,
  input  logic [31:0] mem_target_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] link_addr_o
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic        taken;

  assign pc_plus4   = pc_i + 32'd4;
  assign branch_off = {{14{instr_index_i[15]}}, instr_index_i[15:0], 2'b00};

  assign taken = is_jump_i
               | (zero_branch_i   & (alu_zero_i == need_zero_i))
               | (status_branch_i & (status_z_i == need_st_z_i));

  always_comb begin
    target = pc_plus4;
    case (pc_select_i)
      PCSEL_SEQ: target = pc_plus4 + branch_off;
      PCSEL_J26: target = {pc_plus4[31:28], instr_index_i, 2'b00};
      PCSEL_REG: target = word_align(reg_target_i);
      PCSEL_MEM: target = word_align(mem_target_i);
      default:   target = pc_plus4;
    endcase
  end

  assign next_pc_o   = taken ? target : pc_plus4;
  assign link_addr_o = pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/EXEC/HALT sequencer owning the PC, the
// instruction register and the status Z flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  output logic        instr_valid_o,
  output logic [31:0] link_addr_o,
  input  logic        is_jump_i,
  input  logic        zero_branch_i,
  input  logic        need_zero_i,
  input  logic        status_branch_i,
  input  logic        need_st_z_i,
  input  logic [1:0]  pc_select_i,
  input  logic        alu_zero_i,
  input  logic [31:0] reg_target_i,
  input  logic [31:0] mem_target_i,
  input  logic        status_we_i,
  input  logic        status_z_in_i,
  input  logic        halt_i,
  output logic        status_z_o,
  output logic        halted_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        z_q, z_d;
  logic [31:0] next_pc;

  fetch_unit_next_pc u_next_pc (
    .pc_i            (pc_q),
    .instr_index_i   (ir_q[25:0]),
    .status_z_i      (z_q),
    .is_jump_i       (is_jump_i),
    .zero_branch_i   (zero_branch_i),
    .need_zero_i     (need_zero_i),
    .status_branch_i (status_branch_i),
    .need_st_z_i     (need_st_z_i),
    .pc_select_i     (pc_select_i),
    .alu_zero_i      (alu_zero_i),
    .reg_target_i    (reg_target_i),
    .mem_target_i    (mem_target_i),
    .next_pc_o       (next_pc),
    .link_addr_o     (link_addr_o)
  );

  // Z updates at the EXEC closing edge, after next_pc has already consumed the old value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    case (state_q)
      FS_FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = FS_EXEC;
        end
      end
      FS_EXEC: begin
        pc_d = next_pc;
        if (status_we_i) begin
          z_d = status_z_in_i;
        end
        state_d = halt_i ? FS_HALT : FS_FETCH;
      end
      FS_HALT: state_d = FS_HALT;
      default: state_d = FS_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FS_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  assign imem_req_o    = (state_q == FS_FETCH);
  assign imem_addr_o   = pc_q;
  assign instruction_o = ir_q;
  assign instr_valid_o = (state_q == FS_EXEC);
  assign halted_o      = (state_q == FS_HALT);
  assign status_z_o    = z_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: walks a hand-computed program of jumps and
// branches, then checks async reset and the HALT state.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instruction_o;
  logic        instr_valid_o;
  logic [31:0] link_addr_o;
  logic        is_jump_i, zero_branch_i, need_zero_i, status_branch_i, need_st_z_i;
  logic [1:0]  pc_select_i;
  logic        alu_zero_i;
  logic [31:0] reg_target_i, mem_target_i;
  logic        status_we_i, status_z_in_i, halt_i;
  logic        status_z_o, halted_o;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .instruction_o   (instruction_o),
    .instr_valid_o   (instr_valid_o),
    .link_addr_o     (link_addr_o),
    .is_jump_i       (is_jump_i),
    .zero_branch_i   (zero_branch_i),
    .need_zero_i     (need_zero_i),
    .status_branch_i (status_branch_i),
    .need_st_z_i     (need_st_z_i),
    .pc_select_i     (pc_select_i),
    .alu_zero_i      (alu_zero_i),
    .reg_target_i    (reg_target_i),
    .mem_target_i    (mem_target_i),
    .status_we_i     (status_we_i),
    .status_z_in_i   (status_z_in_i),
    .halt_i          (halt_i),
    .status_z_o      (status_z_o),
    .halted_o        (halted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic setCtrl(input logic jmp, input logic zb, input logic nz,
                         input logic sb, input logic ns, input logic [1:0] sel,
                         input logic az, input logic [31:0] rt, input logic [31:0] mt,
                         input logic we, input logic zin, input logic hlt);
    is_jump_i = jmp; zero_branch_i = zb; need_zero_i = nz;
    status_branch_i = sb; need_st_z_i = ns; pc_select_i = sel;
    alu_zero_i = az; reg_target_i = rt; mem_target_i = mt;
    status_we_i = we; status_z_in_i = zin; halt_i = hlt;
  endtask

  // Called at a negedge in FETCH; returns at the negedge after the EXEC closing edge.
  task automatic applyStimulus(input int waits, input logic [31:0] rdata,
                               input logic [31:0] pcExp);
    for (int i = 0; i <= waits; i++) begin
      checkOutput("fetch_req", {31'b0, imem_req_o}, 32'd1);
      checkOutput("fetch_addr", imem_addr_o, pcExp);
      checkOutput("fetch_valid", {31'b0, instr_valid_o}, 32'd0);
      imem_ack_i   = (i == waits);
      imem_rdata_i = (i == waits) ? rdata : 32'hDEAD_BEEF;
      @(posedge clk_i); @(negedge clk_i);
    end
    // A stray ack during EXEC must not disturb the instruction register.
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hBADC_0DE0;
    checkOutput("exec_valid", {31'b0, instr_valid_o}, 32'd1);
    checkOutput("exec_req", {31'b0, imem_req_o}, 32'd0);
    checkOutput("exec_instr", instruction_o, rdata);
    checkOutput("exec_link", link_addr_o, pcExp + 32'd4);
    @(posedge clk_i); @(negedge clk_i);
    imem_ack_i = 1'b0;
    checkOutput("ir_stable", instruction_o, rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    imem_ack_i = 1'b0;
    imem_rdata_i = 32'h0;
    setCtrl(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
    #2;
    checkOutput("rst_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("rst_addr", imem_addr_o, 32'h0);
    checkOutput("rst_link", link_addr_o, 32'h4);
    checkOutput("rst_instr", instruction_o, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("rst_halted", {31'b0, halted_o}, 32'd0);
    checkOutput("rst_z", {31'b0, status_z_o}, 32'd0);
    #10 reset_i = 1'b0;
    @(negedge clk_i);

    // nop with two wait cycles, sequential to 4
    applyStimulus(2, 32'h0000_0000, 32'h0);
    // jr to 0x103 -> aligned 0x100
    setCtrl(1, 0, 0, 0, 0, 2'b10, 0, 32'h0000_0103, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h4);
    // j target26 at 0x100 -> 0x10
    setCtrl(1, 0, 0, 0, 0, 2'b01, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(1, 32'h0800_0004, 32'h100);
    setCtrl(1, 0, 0, 0, 0, 2'b10, 0, 32'h0000_0020, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h10);
    // bne taken at 0x20 -> 0x24 - 16 = 0x14
    setCtrl(0, 1, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h154B_FFFC, 32'h20);
    setCtrl(1, 0, 0, 0, 0, 2'b10, 0, 32'h0000_0020, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h14);
    // bne not taken at 0x20 -> 0x24
    setCtrl(0, 1, 0, 0, 0, 2'b00, 1, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h154B_FFFC, 32'h20);
    // status branch sees old Z=0 while writing Z=1 -> not taken, 0x28
    setCtrl(0, 0, 0, 1, 1, 2'b01, 0, 32'h0, 32'h0, 1, 1, 0);
    applyStimulus(0, 32'h0800_0004, 32'h24);
    checkOutput("z_after_we", {31'b0, status_z_o}, 32'd1);
    // same branch with Z=1 now taken -> target26 0x10
    setCtrl(0, 0, 0, 1, 1, 2'b01, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0800_0004, 32'h28);
    setCtrl(1, 0, 0, 0, 0, 2'b10, 0, 32'h0000_0203, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h10);
    setCtrl(1, 0, 0, 0, 0, 2'b10, 0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h200);
    // not taken at top of memory wraps to 0 (link also 0)
    setCtrl(0, 0, 0, 0, 0, 2'b10, 0, 32'h1234_5678, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0000, 32'hFFFF_FFFC);
    setCtrl(1, 0, 0, 0, 0, 2'b10, 0, 32'h0000_0080, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h0);

    // async reset in the middle of a fetch wait at 0x80
    imem_ack_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    checkOutput("wait_addr", imem_addr_o, 32'h80);
    #2 reset_i = 1'b1;
    #1;
    checkOutput("arst_addr", imem_addr_o, 32'h0);
    checkOutput("arst_link", link_addr_o, 32'h4);
    checkOutput("arst_instr", instruction_o, 32'h0);
    checkOutput("arst_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("arst_z", {31'b0, status_z_o}, 32'd0);
    @(negedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);

    // memory-indirect jump 0x43 -> 0x40, then halt with a Z write
    setCtrl(1, 0, 0, 0, 0, 2'b11, 0, 32'h0, 32'h0000_0043, 0, 0, 0);
    applyStimulus(0, 32'h0000_0008, 32'h0);
    setCtrl(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 1, 1);
    applyStimulus(0, 32'h0000_000D, 32'h40);
    checkOutput("halt_z", {31'b0, status_z_o}, 32'd1);
    setCtrl(1, 1, 1, 1, 1, 2'b11, 1, 32'h0, 32'h0000_0100, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = $urandom;
      checkOutput("halt_halted", {31'b0, halted_o}, 32'd1);
      checkOutput("halt_req", {31'b0, imem_req_o}, 32'd0);
      checkOutput("halt_valid", {31'b0, instr_valid_o}, 32'd0);
      checkOutput("halt_pc", imem_addr_o, 32'h44);
      checkOutput("halt_instr", instruction_o, 32'h0000_000D);
      @(posedge clk_i); @(negedge clk_i);
    end
    checkOutput("halt_z_frozen", {31'b0, status_z_o}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and next-PC stage for the MIPS processor. Sits directly upstream of `control`. Owns the PC, the status Z flag and the instruction register. Fetches one word over a req/ack instruction-memory port, presents it to `control` and the datapath for exactly one execute cycle, then resolves the next PC from the control outputs `is_jump`, `zero_branch`/`need_zero`, `status_branch`/`need_st_Z` and `pc_select`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `imem_req`  out  1  fetch request; held until ack
- `imem_addr`  out  32  word address to fetch; equals PC
- `imem_ack`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction
- `instruction`  out  32  instruction register, feeds `control`
- `instr_valid`  out  1  high for the single EXEC cycle
- `link_addr`  out  32  PC+4, written to rt/rd/$31 on link instructions
- `is_jump`, `zero_branch`, `need_zero`, `status_branch`, `need_st_Z`  in  1 each  from `control`
- `pc_select`  in  2  00 = seq/PC-relative branch, 01 = target26, 10 = register, 11 = memory
- `alu_zero`  in  1  ALU zero result
- `reg_target`  in  32  rs value
- `mem_target`  in  32  data-memory read value
- `status_we`  in  1  update Z this EXEC cycle
- `status_z_in`  in  1  new Z value
- `halt`  in  1  stop after the current instruction
- `status_z`  out  1  current Z flag
- `halted`  out  1  high in HALT

## Operation
- States: FETCH, EXEC, HALT. Reset enters FETCH.
- FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`, latch `imem_rdata` into `instruction` and go to EXEC.
- EXEC: `instr_valid`=1 and `imem_req`=0. At the clock edge:
  - PC <= next_pc
  - Z <= `status_z_in` if `status_we`
  - go to HALT if `halt`, else to FETCH
- Taken condition: `is_jump` | (`zero_branch` & (`alu_zero`==`need_zero`)) | (`status_branch` & (Z==`need_st_Z`)).
  - Z is the pre-update value, so a Z write and a status branch in the same instruction see the old Z.
- next_pc when not taken: PC+4.
- next_pc when taken, by `pc_select`:
  - 00: PC+4 + (sext(instruction[15:0]) << 2)
  - 01: {PC+4[31:28], instruction[25:0], 2'b00}
  - 10: `reg_target`
  - 11: `mem_target`
- Arithmetic: all 32-bit modulo 2^32. Wrap-around from 32'hFFFF_FFFC goes to 0 silently. Bits [1:0] of `reg_target`/`mem_target` are forced to 0.
- `link_addr` = PC+4, valid whenever `instr_valid`.
- HALT: absorbing. `imem_req`=0, `instr_valid`=0, PC and Z frozen. Only reset exits.
- Reset values: PC=`RESET_PC`, `instruction`=0, Z=0, `imem_req`=1 (FETCH), `instr_valid`=0, `halted`=0, `imem_addr`=`RESET_PC`, `link_addr`=`RESET_PC`+4.
- Reset mid-fetch abandons the request. A late `imem_ack` arriving after reset deasserts is treated as the ack for `RESET_PC`; the memory model must not deliver stale acks.

## Timing
- Minimum 2 cycles per instruction: 1 FETCH with same-cycle ack, plus 1 EXEC. Each extra wait cycle adds 1.
- `imem_ack` is ignored outside FETCH.
- `instruction` is stable from the EXEC entry edge until the next ack edge.
- Control inputs are sampled only at the EXEC closing edge and are don't-care elsewhere.
- `halt` is sampled only in EXEC. The current instruction completes, including its PC and Z update.

## Structure
- Shared package `_const.v` holds:
  - state encodings `FS_FETCH`, `FS_EXEC`, `FS_HALT`
  - `PCSEL_SEQ`, `PCSEL_J26`, `PCSEL_REG`, `PCSEL_MEM` (2'b00..2'b11)
- One sub-module: `next_pc`, purely combinational. It computes the taken condition and the target mux from PC, instruction, Z and the control inputs.
- `fetch_unit` holds the FSM, PC, IR and Z registers.

## Test plan
- Reset with `RESET_PC`=0 and a 2-wait-cycle ack:
  - `imem_addr`=0 held for 3 cycles
  - then `instr_valid` for 1 cycle
  - then `imem_addr`=4
- Instruction 32'h08000004 (j), `is_jump`=1, `pc_select`=01, at PC=0x100 → next `imem_addr`=0x0000_0010, `link_addr` was 0x104.
- Instruction 32'h154BFFFC (bne), `zero_branch`=1, `need_zero`=0, PC=0x20:
  - `alu_zero`=0 → next PC 0x14
  - `alu_zero`=1 → next PC 0x24
- `status_branch`=1, `need_st_Z`=1, Z=0, with `status_we`=1 and `status_z_in`=1 in the same EXEC → not taken (PC+4). `status_z`=1 afterwards.
- jr: `pc_select`=10, `reg_target`=0x0000_0203 → next PC 0x200. Separately, PC=0xFFFF_FFFC not taken → next PC 0.
- `halt`=1 in EXEC at PC=0x40 → PC becomes 0x44, then `halted`=1 and `imem_req`=0 held for 10 cycles.
- Assert `reset` asynchronously during a FETCH wait → outputs return to reset values immediately, without a clock edge.
